// File: rtl/icache_sa.sv
// Set-associative read-only instruction cache with PLRU-m replacement and line refill.
// Latency: a hit responds 1 cycle after acceptance; a miss responds 1 cycle after the last refill beat.
// Backpressure: req_ready drops on a miss, during refill/response and while flushing; rsp has none.
module icache_sa #(
    parameter int ADDR_W     = 32,
    parameter int WAYS       = 4,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 4
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    input  logic              inv_all,
    output logic              stat_hit,
    output logic              stat_miss
);
    localparam int OFS_W = $clog2(LINE_WORDS * 4);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFS_W;
    localparam int WRD_W = OFS_W - 2;
    localparam int WAY_W = $clog2(WAYS);
    localparam logic [IDX_W-1:0] LAST_SET  = IDX_W'(SETS - 1);
    localparam logic [WRD_W-1:0] LAST_BEAT = WRD_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {FLUSH, IDLE, REFILL_REQ, REFILL_DATA, RESP} state_t;
    state_t state_q, state_d;

    logic [IDX_W-1:0]  cnt_q;
    logic [WRD_W-1:0]  beat_q;
    logic              lk_vld_q;
    logic              inv_pend_q;
    logic [ADDR_W-1:2] lk_addr_q;

    logic [TAG_W-1:0] tag_q  [WAYS][SETS];
    logic [SETS-1:0]  v_q    [WAYS];
    logic [WAYS-1:0]  mru_q  [SETS];
    logic [31:0]      data_q [WAYS][SETS][LINE_WORDS];
    logic [31:0]      lbuf_q [LINE_WORDS];

    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] lk_idx;
    logic [WRD_W-1:0] lk_word;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] vic;
    logic             fill;
    logic             unused_addr_lsb;

    assign lk_tag  = lk_addr_q[ADDR_W-1 -: TAG_W];
    assign lk_idx  = lk_addr_q[OFS_W +: IDX_W];
    assign lk_word = lk_addr_q[2 +: WRD_W];
    assign fill    = (state_q == REFILL_DATA) && mem_rsp_valid && (beat_q == LAST_BEAT);
    assign unused_addr_lsb = ^req_addr[1:0];

    function automatic logic [WAYS-1:0] plru(input logic [WAYS-1:0] m, input logic [WAY_W-1:0] w);
        logic [WAYS-1:0] s;
        s = m | (WAYS'(1) << w);
        return (&s) ? (WAYS'(1) << w) : s;
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (v_q[w][lk_idx] && (tag_q[w][lk_idx] == lk_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Second pass overrides the first only when some way is invalid; descending loops keep the lowest index.
    always_comb begin
        vic = '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!mru_q[lk_idx][w]) vic = WAY_W'(w);
        for (int w = WAYS - 1; w >= 0; w--)
            if (!v_q[w][lk_idx]) vic = WAY_W'(w);
    end

    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_data      = '0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        stat_hit      = 1'b0;
        stat_miss     = 1'b0;
        case (state_q)
            FLUSH: begin
                if (!inv_all && (cnt_q == LAST_SET)) state_d = IDLE;
            end
            IDLE: begin
                if (lk_vld_q && hit) begin
                    rsp_valid = 1'b1;
                    rsp_data  = data_q[hit_way][lk_idx][lk_word];
                    stat_hit  = 1'b1;
                end
                stat_miss = lk_vld_q && !hit;
                req_ready = !(lk_vld_q && !hit) && !inv_all && !inv_pend_q;
                if (lk_vld_q && !hit)           state_d = REFILL_REQ;
                else if (inv_all || inv_pend_q) state_d = FLUSH;
            end
            REFILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {lk_addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                if (mem_req_ready) state_d = REFILL_DATA;
            end
            REFILL_DATA: begin
                if (fill) state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = lbuf_q[lk_word];
                state_d   = (inv_all || inv_pend_q) ? FLUSH : IDLE;
            end
            default: state_d = FLUSH;
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= FLUSH;
            cnt_q      <= '0;
            beat_q     <= '0;
            lk_vld_q   <= 1'b0;
            inv_pend_q <= 1'b0;
            lk_addr_q  <= '0;
        end else begin
            state_q  <= state_d;
            lk_vld_q <= req_valid && req_ready;
            if (req_valid && req_ready) lk_addr_q <= req_addr[ADDR_W-1:2];
            if (state_d == FLUSH && (state_q != FLUSH || inv_all)) cnt_q <= '0;
            else if (state_q == FLUSH)                            cnt_q <= cnt_q + 1'b1;
            if (state_d == FLUSH) inv_pend_q <= 1'b0;
            else if (inv_all)     inv_pend_q <= 1'b1;
            if (state_q == REFILL_REQ)                         beat_q <= '0;
            else if (state_q == REFILL_DATA && mem_rsp_valid) beat_q <= beat_q + 1'b1;
        end
    end

    // Storage arrays carry no reset: the flush walk clears V and MRU before any lookup can happen.
    always_ff @(posedge CLK) begin
        if (state_q == FLUSH) begin
            for (int w = 0; w < WAYS; w++) v_q[w][cnt_q] <= 1'b0;
            mru_q[cnt_q] <= '0;
        end
        if (state_q == REFILL_DATA && mem_rsp_valid) lbuf_q[beat_q] <= mem_rsp_data;
        if (stat_hit) mru_q[lk_idx] <= plru(mru_q[lk_idx], hit_way);
        if (fill) begin
            tag_q[vic][lk_idx] <= lk_tag;
            v_q[vic][lk_idx]   <= 1'b1;
            mru_q[lk_idx]      <= plru(mru_q[lk_idx], vic);
            for (int i = 0; i < LINE_WORDS; i++) data_q[vic][lk_idx][i] <= lbuf_q[i];
            data_q[vic][lk_idx][LINE_WORDS-1] <= mem_rsp_data;
        end
    end
endmodule

// File: tb/tb_icache_sa.sv
// Bench for icache_sa: directed scenarios plus random reads against a behavioural cache model.
// Latency: checks hit responses one cycle after acceptance and refill responses after the last beat.
// Backpressure: memory side inserts random request stalls and beat gaps.
module tb_icache_sa;
    localparam int AW = 32, WAYS = 4, SETS = 256, LW = 4;

    logic          CLK = 1'b0, nRESET = 1'b0;
    logic          req_valid = 1'b0, mem_req_ready = 1'b0, mem_rsp_valid = 1'b0, inv_all = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   mem_rsp_data = '0;
    logic          req_ready, rsp_valid, mem_req_valid, stat_hit, stat_miss;
    logic [31:0]   rsp_data;
    logic [AW-1:0] mem_req_addr;

    int checks = 0, errors = 0;

    // Model: per-set list of resident tags and MRU bits, indexed by way.
    bit mv [WAYS][SETS];
    int mt [WAYS][SETS];
    bit mm [SETS][WAYS];

    always #5 CLK = ~CLK;

    icache_sa #(.ADDR_W(AW), .WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (
        .CLK(CLK), .nRESET(nRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .inv_all(inv_all), .stat_hit(stat_hit), .stat_miss(stat_miss)
    );

    function automatic logic [31:0] memval(input logic [31:0] line, input int i);
        if (line == 32'h1230) return 32'hA0 + i;
        return (line * 32'h9E3779B1) ^ (i * 32'h01000193) ^ 32'h5A5A0000;
    endfunction

    function automatic void model_flush();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                mv[w][s] = 1'b0;
                mm[s][w] = 1'b0;
            end
    endfunction

    function automatic void model_touch(input int s, input int w);
        bit all1;
        mm[s][w] = 1'b1;
        all1 = 1'b1;
        for (int k = 0; k < WAYS; k++) if (!mm[s][k]) all1 = 1'b0;
        if (all1) for (int k = 0; k < WAYS; k++) mm[s][k] = (k == w);
    endfunction

    // Returns predicted hit and applies the hit or fill to the model.
    function automatic bit model_access(input logic [31:0] addr);
        int s, t, vw;
        s  = (addr >> 4) % SETS;
        t  = addr >> 12;
        vw = -1;
        for (int w = 0; w < WAYS; w++)
            if (mv[w][s] && mt[w][s] == t) begin
                model_touch(s, w);
                return 1'b1;
            end
        for (int w = 0; w < WAYS && vw < 0; w++) if (!mv[w][s]) vw = w;
        for (int w = 0; w < WAYS && vw < 0; w++) if (!mm[s][w]) vw = w;
        mv[vw][s] = 1'b1;
        mt[vw][s] = t;
        model_touch(s, vw);
        return 1'b0;
    endfunction

    task automatic count_flush(output int n);
        bit bad;
        n = 0;
        bad = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge CLK);
            inv_all = 1'b0;
            #1;
            if (req_ready) break;
            if (mem_req_valid || rsp_valid) bad = 1'b1;
            n++;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL flush_quiet: mem_req_valid/rsp_valid seen during flush"); end
    endtask

    task automatic read_one(input logic [31:0] addr, input int inv_at, input int rst_at, output bit obs_hit);
        bit eh, bad;
        int n;
        logic [31:0] line, exp;
        eh   = model_access(addr);
        line = addr & ~32'hF;
        exp  = memval(line, int'(addr[3:2]));
        @(negedge CLK);
        req_valid = 1'b1;
        req_addr  = addr;
        #1;
        n = 0;
        while (!req_ready && n < 2000) begin @(negedge CLK); #1; n++; end
        checks++;
        if (!req_ready) begin errors++; $display("FAIL accept_timeout addr=%h", addr); end
        @(negedge CLK);
        req_valid = 1'b0;
        req_addr  = $urandom;
        #1;
        obs_hit = stat_hit;
        checks++;
        if (stat_hit !== eh || stat_miss !== !eh) begin
            errors++;
            $display("FAIL lookup addr=%h hit=%b miss=%b expected hit=%b", addr, stat_hit, stat_miss, eh);
        end
        if (eh) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp || mem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL hit_rsp addr=%h vld=%b data=%h memreq=%b expected 1/%h/0",
                         addr, rsp_valid, rsp_data, mem_req_valid, exp);
            end
            return;
        end
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL miss_ready req_ready=%b expected 0", req_ready); end
        n = 0;
        while (!mem_req_valid && n < 50) begin @(negedge CLK); #1; n++; end
        bad = 1'b0;
        repeat ($urandom_range(0, 3)) begin
            if (mem_req_valid !== 1'b1 || mem_req_addr !== line) bad = 1'b1;
            @(negedge CLK);
            #1;
        end
        checks++;
        if (bad || mem_req_valid !== 1'b1 || mem_req_addr !== line) begin
            errors++;
            $display("FAIL refill_req vld=%b addr=%h expected 1/%h", mem_req_valid, mem_req_addr, line);
        end
        mem_req_ready = 1'b1;
        @(negedge CLK);
        mem_req_ready = 1'b0;
        for (int i = 0; i < LW; i++) begin
            repeat ($urandom_range(0, 1)) @(negedge CLK);
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = memval(line, i);
            inv_all       = (i == inv_at);
            @(negedge CLK);
            mem_rsp_valid = 1'b0;
            inv_all       = 1'b0;
            if (i == rst_at) begin
                nRESET = 1'b0;
                #1;
                checks++;
                if (mem_req_valid !== 1'b0 || rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_abort mem_req_valid=%b rsp_valid=%b expected 0/0", mem_req_valid, rsp_valid);
                end
                model_flush();
                return;
            end
        end
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp) begin
            errors++;
            $display("FAIL refill_rsp addr=%h vld=%b data=%h expected 1/%h", addr, rsp_valid, rsp_data, exp);
        end
    endtask

    task automatic test_reset();
        int n;
        #1;
        checks++;
        if ({req_ready, rsp_valid, mem_req_valid, stat_hit, stat_miss} !== 5'b0 || rsp_data !== 0 || mem_req_addr !== 0) begin
            errors++;
            $display("FAIL reset_outputs rdy=%b rv=%b mv=%b h=%b m=%b rd=%h ma=%h expected all 0",
                     req_ready, rsp_valid, mem_req_valid, stat_hit, stat_miss, rsp_data, mem_req_addr);
        end
        model_flush();
        @(posedge CLK);
        #2 nRESET = 1'b1;
        count_flush(n);
        checks++;
        if (n != SETS) begin errors++; $display("FAIL reset_flush_len got=%0d expected %0d", n, SETS); end
    endtask

    task automatic test_cold_miss();
        bit h;
        read_one(32'h0000_1234, -1, -1, h);
        checks++;
        if (h !== 1'b0) begin errors++; $display("FAIL cold_miss hit=%b expected 0", h); end
        read_one(32'h0000_1238, -1, -1, h);
        checks++;
        if (h !== 1'b1) begin errors++; $display("FAIL warm_hit hit=%b expected 1", h); end
    endtask

    task automatic test_back_to_back();
        bit eh [4];
        logic [31:0] a;
        for (int k = 0; k < 4; k++) eh[k] = model_access(32'h1230 + 4 * k);
        for (int k = 0; k <= 4; k++) begin
            @(negedge CLK);
            req_valid = (k < 4);
            a         = 32'h1230 + 4 * k;
            req_addr  = a;
            #1;
            if (k < 4) begin
                checks++;
                if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready k=%0d rdy=%b expected 1", k, req_ready); end
            end
            if (k > 0) begin
                checks++;
                if (rsp_valid !== eh[k-1] || stat_hit !== eh[k-1] || rsp_data !== memval(32'h1230, k - 1)) begin
                    errors++;
                    $display("FAIL b2b_rsp k=%0d vld=%b hit=%b data=%h expected %b/%b/%h",
                             k - 1, rsp_valid, stat_hit, rsp_data, eh[k-1], eh[k-1], memval(32'h1230, k - 1));
                end
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_inv_refill();
        bit h;
        int n;
        read_one(32'h0000_5678, 1, -1, h);
        model_flush();
        count_flush(n);
        checks++;
        if (n != SETS) begin errors++; $display("FAIL inv_refill_flush got=%0d expected %0d", n, SETS); end
        read_one(32'h0000_5678, -1, -1, h);
        checks++;
        if (h !== 1'b0) begin errors++; $display("FAIL inv_refill_remiss hit=%b expected 0", h); end
    endtask

    task automatic test_inv_idle();
        int n;
        bit bad;
        @(negedge CLK);
        inv_all   = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0000_0230;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL inv_idle_ready rdy=%b expected 0", req_ready); end
        bad = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            inv_all = 1'b0;
            #1;
            if (req_ready !== 1'b0) bad = 1'b1;
        end
        inv_all = 1'b1;
        count_flush(n);
        req_valid = 1'b0;
        model_flush();
        checks++;
        if (bad || n != SETS) begin
            errors++;
            $display("FAIL inv_restart_flush got=%0d early_ready=%b expected %0d/0", n, bad, SETS);
        end
    endtask

    task automatic test_plru();
        bit h;
        logic [31:0] seq [7];
        bit want [7];
        seq = '{32'h0230, 32'h1230, 32'h2230, 32'h3230, 32'h0230, 32'h4230, 32'h1230};
        want = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 7; k++) begin
            read_one(seq[k], -1, -1, h);
            checks++;
            if (h !== want[k]) begin errors++; $display("FAIL plru_step%0d addr=%h hit=%b expected %b", k, seq[k], h, want[k]); end
        end
        read_one(32'h0234, -1, -1, h);
        checks++;
        if (h !== 1'b1) begin errors++; $display("FAIL plru_keep hit=%b expected 1", h); end
    endtask

    task automatic test_random();
        bit h;
        int n, sets [3];
        logic [31:0] a;
        sets = '{32'h23, 32'h24, 32'h9C};
        for (int k = 0; k < 80; k++) begin
            a = ($urandom_range(0, 6) << 12) | (sets[$urandom_range(0, 2)] << 4) |
                ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            read_one(a, -1, -1, h);
            if ($urandom_range(0, 19) == 0) begin
                @(negedge CLK);
                inv_all = 1'b1;
                count_flush(n);
                model_flush();
                checks++;
                if (n != SETS) begin errors++; $display("FAIL rand_inv_flush got=%0d expected %0d", n, SETS); end
            end
        end
    endtask

    task automatic test_reset_mid_refill();
        bit h, bad;
        int n;
        read_one(32'h0000_7774, -1, 2, h);
        bad = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            #1;
            if (rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL reset_hold outputs active during reset"); end
        @(posedge CLK);
        #2 nRESET = 1'b1;
        count_flush(n);
        checks++;
        if (n != SETS) begin errors++; $display("FAIL reset_mid_flush got=%0d expected %0d", n, SETS); end
        read_one(32'h0000_7774, -1, -1, h);
        checks++;
        if (h !== 1'b0) begin errors++; $display("FAIL reset_mid_remiss hit=%b expected 0", h); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_inv_refill();
        test_inv_idle();
        test_plru();
        test_random();
        test_reset_mid_refill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
- Parametrised, read-only, set-associative instruction cache. Successor to the fixed 4-way/256-set/16-byte-line instruction cache.
- Way count, set count, line length and address width are all generic.
- Adds what the earlier block lacked:
  - a working lookup pipeline;
  - a line-refill state machine toward the memory side;
  - PLRU-m replacement;
  - full-cache invalidation.
- Sits between the fetch unit (request/response side) and the bus/memory interface (refill side).

Parameters:
- ADDR_W, 32: address width in bits.
- WAYS, 4: associativity; power of 2, range 2..8.
- SETS, 256: number of sets; power of 2, at least 2.
- LINE_WORDS, 4: 32-bit words per line; power of 2, range 2..16.
- Derived values:
  - OFS_W = log2(LINE_WORDS*4)
  - IDX_W = log2(SETS)
  - TAG_W = ADDR_W - IDX_W - OFS_W (20 at defaults)

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  cache can accept a request this cycle.
- req_addr  in  ADDR_W  fetch byte address; bits [1:0] are ignored.
- rsp_valid  out  1  response data valid; one-cycle pulse, no back-pressure.
- rsp_data  out  32  fetched instruction word.
- mem_req_valid  out  1  refill request.
- mem_req_ready  in  1  memory accepts the refill request.
- mem_req_addr  out  ADDR_W  line-aligned refill address; low OFS_W bits are 0.
- mem_rsp_valid  in  1  refill data beat valid.
- mem_rsp_data  in  32  refill beat; words arrive in order 0..LINE_WORDS-1.
- inv_all  in  1  one-cycle pulse requesting invalidation of the whole cache.
- stat_hit  out  1  one-cycle pulse per hit.
- stat_miss  out  1  one-cycle pulse per miss.

Behaviour:
- Reset (nRESET=0, asynchronous):
  - req_ready, rsp_valid, mem_req_valid, stat_hit and stat_miss go to 0; rsp_data and mem_req_addr go to 0.
  - FSM goes to FLUSH with the set counter at 0.
  - Any refill in progress is abandoned. The memory side is reset by the same reset, so no late beats arrive.
- Line storage per way and set: TAG_W tag, V bit, LINE_WORDS data words. Per set: WAYS MRU bits.
- FSM states: FLUSH, IDLE, REFILL_REQ, REFILL_DATA, RESP.
- FLUSH:
  - Clears V and all MRU bits of one set per cycle, walking set 0 to SETS-1.
  - Lasts exactly SETS cycles, then goes to IDLE. req_ready=0 throughout.
- IDLE and the lookup stage:
  - A request is accepted when req_valid & req_ready.
  - The address is registered; the tags of all ways at that index are compared in the next cycle (lookup cycle).
  - Hit: rsp_valid=1 with the addressed word and stat_hit=1 in the lookup cycle, so latency is 1. req_ready stays 1, giving back-to-back throughput of 1 request per cycle.
  - Miss: stat_miss=1 and req_ready=0 in the lookup cycle (combinational from the compare); next state is REFILL_REQ.
- REFILL_REQ:
  - mem_req_valid=1 and mem_req_addr = {tag, index, OFS_W zeros}, both held stable until mem_req_ready.
  - Then go to REFILL_DATA with the beat counter at 0.
- REFILL_DATA:
  - Each mem_rsp_valid beat is captured into the line buffer at the beat counter position, and the counter increments.
  - On beat LINE_WORDS-1, the line is written to the victim way with V=1 and the MRU bits are updated. Next state is RESP.
- RESP: rsp_valid=1 with the requested word taken from the line buffer, for one cycle. Then IDLE with req_ready=1.
- Victim selection:
  - The lowest-index way with V=0.
  - Otherwise the lowest-index way whose MRU bit is 0.
- PLRU-m update on every hit or fill of way w: set MRU[w]. If all bits would then be 1, the set instead ends with MRU[w]=1 and every other bit 0.
- inv_all handling:
  - In IDLE with no lookup pending: enter FLUSH in the next cycle.
  - With a lookup pending, or during REFILL_* or RESP: the pulse is latched. The current hit response or refill-plus-RESP completes, and FLUSH starts immediately afterwards.
  - A line just refilled is therefore also invalidated.
  - inv_all during FLUSH restarts the walk at set 0.
- Pending request on inv_all: a request that is valid but not accepted stays pending; req_ready=0 until FLUSH ends.
- Address: bits [OFS_W-1:2] select the word; bits [1:0] are ignored.
- Only one miss is outstanding at a time; there is no hit-under-miss.

Test Plan:
- Reset release with defaults → req_ready=0 for exactly 256 cycles, then 1; no mem_req_valid.
- Cold read of 0x0000_1234 → stat_miss, then mem_req_addr=0x0000_1230; beats 0xA0..0xA3 → rsp_valid with rsp_data=0xA1. A following read of 0x0000_1238 → rsp_data=0xA2 one cycle after acceptance, with stat_hit and no mem_req_valid.
- Four consecutive-cycle reads of 0x1230, 0x1234, 0x1238, 0x123C after fill → four rsp_valid pulses on consecutive cycles with data 0xA0..0xA3, four stat_hit pulses, req_ready constantly 1.
- Set index 0x23, tags 0..3 filled via addresses 0x0230, 0x1230, 0x2230, 0x3230 → after the 4th fill only MRU[3] is set. A hit on 0x0230 sets MRU = {0,3}. A miss on 0x4230 → victim way 1. A subsequent read of 0x1230 misses; a read of 0x0230 hits.
- inv_all pulse during REFILL_DATA beat 1 → refill completes and the response is delivered, then req_ready=0 for 256 cycles; re-reading the same address misses.
- nRESET asserted after refill beat 2 → mem_req_valid and rsp_valid are 0 immediately and no response is issued. After release: 256-cycle flush, then the same address misses.
